// File: rtl/spi_arbiter.sv
// Round-robin burst controller sharing one byte-level SPI master engine among
// NUM_REQ requesters; chip-select is held for a whole burst, then idled.
module spi_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int LEN_WIDTH      = 4,
  parameter int CS_IDLE_CYCLES = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_tx_data_i,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic                            tx_ack_o,
  output logic                            rx_valid_o,
  output logic [DATA_WIDTH-1:0]           rx_data_o,
  output logic                            done_o,
  output logic [NUM_REQ-1:0]              cs_n_o,
  output logic                            eng_start_o,
  output logic [DATA_WIDTH-1:0]           eng_tx_data_o,
  input  logic                            eng_done_i,
  input  logic [DATA_WIDTH-1:0]           eng_rx_data_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(CS_IDLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, WAIT, DONECHK, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d, ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d, cs_n_q, cs_n_d;
  logic                    tx_ack_q, tx_ack_d, eng_start_q, eng_start_d;
  logic                    rx_valid_q, rx_valid_d, done_q, done_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d, eng_tx_data_q, eng_tx_data_d;

  logic [LEN_WIDTH-1:0]    len_a [NUM_REQ];
  logic [DATA_WIDTH-1:0]   txd_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign len_a[g] = req_len_i[g*LEN_WIDTH +: LEN_WIDTH];
    assign txd_a[g] = req_tx_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts one past the last winner so the previous owner ranks last.
  logic                    pick_found;
  logic [IW-1:0]           pick_idx, cand;
  logic [NUM_REQ-1:0]      pick_oh;
  logic [LEN_WIDTH-1:0]    pick_len;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!pick_found && req_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_oh  = NUM_REQ'(1) << pick_idx;
    pick_len = len_a[pick_idx];
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ptr_d         = ptr_q;
    rem_d         = rem_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    cs_n_d        = cs_n_q;
    tx_ack_d      = 1'b0;
    eng_start_d   = 1'b0;
    eng_tx_data_d = eng_tx_data_q;
    rx_valid_d    = 1'b0;
    rx_data_d     = rx_data_q;
    done_d        = 1'b0;
    unique case (state_q)
      IDLE: if (pick_found) begin
        state_d = SETUP;
        idx_d   = pick_idx;
        ptr_d   = pick_idx;
        rem_d   = (pick_len == '0) ? LEN_WIDTH'(1) : pick_len;
        grant_d = pick_oh;
        cs_n_d  = ~pick_oh;
      end
      SETUP: begin
        state_d       = LOAD;
        tx_ack_d      = 1'b1;
        eng_start_d   = 1'b1;
        eng_tx_data_d = txd_a[idx_q];
      end
      LOAD: state_d = WAIT;
      WAIT: if (eng_done_i) begin
        state_d    = DONECHK;
        rx_data_d  = eng_rx_data_i;
        rx_valid_d = 1'b1;
        rem_d      = rem_q - 1'b1;
        done_d     = (rem_q == LEN_WIDTH'(1));
      end
      DONECHK: begin
        if (rem_q != '0) begin
          state_d       = LOAD;
          tx_ack_d      = 1'b1;
          eng_start_d   = 1'b1;
          eng_tx_data_d = txd_a[idx_q];
        end else begin
          state_d = HOLD;
          grant_d = '0;
          cs_n_d  = '1;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == CW'(CS_IDLE_CYCLES - 1)) state_d = IDLE;
        else                                  cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      ptr_q         <= IW'(NUM_REQ - 1);
      rem_q         <= '0;
      cnt_q         <= '0;
      grant_q       <= '0;
      cs_n_q        <= '1;
      tx_ack_q      <= 1'b0;
      eng_start_q   <= 1'b0;
      eng_tx_data_q <= '0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ptr_q         <= ptr_d;
      rem_q         <= rem_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      cs_n_q        <= cs_n_d;
      tx_ack_q      <= tx_ack_d;
      eng_start_q   <= eng_start_d;
      eng_tx_data_q <= eng_tx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_data_q     <= rx_data_d;
      done_q        <= done_d;
    end
  end

  assign grant_o       = grant_q;
  assign cs_n_o        = cs_n_q;
  assign tx_ack_o      = tx_ack_q;
  assign eng_start_o   = eng_start_q;
  assign eng_tx_data_o = eng_tx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_data_o     = rx_data_q;
  assign done_o        = done_q;

endmodule
